// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB control unit for the 16-bit TSC CPU.
// Memory phases finish on mem_ready, or after a fixed MEM_LATENCY cycle count.
module multicycle_ctrl_fsm #(
  parameter int WORD_SIZE   = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic [3:0]           micro_pc,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 wwd_en,
  output logic                 illegal,
  output logic [1:0]           pc_src,
  output logic [1:0]           wb_sel,
  output logic [1:0]           reg_dst,
  output logic [3:0]           alu_op,
  output logic                 alu_src,
  output logic [CNT_WIDTH-1:0] num_inst,
  output logic                 is_halted
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MEM  = 4'd3,
    S_WB   = 4'd4,
    S_HALT = 4'd15
  } state_t;

  state_t     state, next_state;
  logic [3:0] wait_cnt;
  logic       retire;
  logic       mem_done;

  logic [3:0] opcode;
  logic [5:0] func;
  logic       unused_bits;
  logic       is_rtype, is_branch, is_adi, is_ori, is_lhi, is_lwd, is_swd;
  logic       is_jmp, is_jal, is_ralu, is_jpr, is_jrl, is_wwd, is_hlt, is_legal;

  assign opcode      = instruction[WORD_SIZE-1 -: 4];
  assign func        = instruction[5:0];
  assign unused_bits = ^instruction[WORD_SIZE-5:6];

  assign is_rtype  = (opcode == 4'd15);
  assign is_branch = (opcode <= 4'd3);
  assign is_adi    = (opcode == 4'd4);
  assign is_ori    = (opcode == 4'd5);
  assign is_lhi    = (opcode == 4'd6);
  assign is_lwd    = (opcode == 4'd7);
  assign is_swd    = (opcode == 4'd8);
  assign is_jmp    = (opcode == 4'd9);
  assign is_jal    = (opcode == 4'd10);
  assign is_ralu   = is_rtype && (func <= 6'd7);
  assign is_jpr    = is_rtype && (func == 6'd25);
  assign is_jrl    = is_rtype && (func == 6'd26);
  assign is_wwd    = is_rtype && (func == 6'd28);
  assign is_hlt    = is_rtype && (func == 6'd29);
  assign is_legal  = (opcode <= 4'd10) || is_ralu || is_jpr || is_jrl || is_wwd || is_hlt;

  // wait_cnt is zero on the first cycle in a state, so the Nth cycle sees N-1
  assign mem_done = (MEM_LATENCY == 0) ? mem_ready : (wait_cnt == 4'(MEM_LATENCY - 1));

  assign micro_pc = state;

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    wwd_en     = 1'b0;
    illegal    = 1'b0;
    pc_src     = 2'd0;
    wb_sel     = 2'd0;
    reg_dst    = 2'd0;
    alu_op     = 4'd0;
    alu_src    = 1'b0;
    case (state)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_done) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        if (is_hlt) begin
          next_state = S_HALT;
          retire     = 1'b1;
        end else begin
          next_state = S_EX;
        end
      end
      S_EX: begin
        if (is_rtype && is_legal) begin
          alu_op = func[3:0];
        end else if (is_ori) begin
          alu_op  = 4'd3;
          alu_src = 1'b1;
        end else if (is_lhi) begin
          alu_op  = 4'd8;
          alu_src = 1'b1;
        end else if (is_branch || is_adi || is_lwd || is_swd) begin
          alu_src = 1'b1;
        end
        if (is_branch) begin
          pc_write = branch_taken;
          pc_src   = 2'd1;
        end else if (is_jmp || is_jal) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end else if (is_jpr || is_jrl) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
        end else if (is_wwd) begin
          wwd_en = 1'b1;
        end else if (!is_legal) begin
          illegal = 1'b1;
        end
        // Most instructions finish here; loads/stores and writers continue
        next_state = S_IF;
        retire     = 1'b1;
        if (is_lwd || is_swd) begin
          next_state = S_MEM;
          retire     = 1'b0;
        end else if (is_ralu || is_adi || is_ori || is_lhi || is_jal || is_jrl) begin
          next_state = S_WB;
          retire     = 1'b0;
        end
      end
      S_MEM: begin
        mem_read  = is_lwd;
        mem_write = is_swd;
        if (mem_done) begin
          if (is_lwd) begin
            next_state = S_WB;
          end else begin
            next_state = S_IF;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (is_ralu) begin
          reg_dst = 2'd1;
        end else if (is_lwd) begin
          wb_sel = 2'd1;
        end else if (is_jal || is_jrl) begin
          wb_sel  = 2'd2;
          reg_dst = 2'd2;
        end
        next_state = S_IF;
        retire     = 1'b1;
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_IF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IF;
      num_inst  <= '0;
      is_halted <= 1'b0;
      wait_cnt  <= 4'd0;
    end else begin
      state <= next_state;
      if (retire) begin
        num_inst <= num_inst + 1'b1;
      end
      if (next_state == S_HALT) begin
        is_halted <= 1'b1;
      end
      if (next_state != state) begin
        wait_cnt <= 4'd0;
      end else if (state == S_IF || state == S_MEM) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised self-checking bench: two instances (ready handshake and fixed
// 3-cycle latency) are each walked through instruction routes by a phase model.
module tb_multicycle_ctrl_fsm;

  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 15;
  localparam int C_BR = 0, C_ADI = 1, C_ORI = 2, C_LHI = 3, C_LWD = 4, C_SWD = 5, C_JMP = 6;
  localparam int C_JAL = 7, C_RALU = 8, C_JPR = 9, C_JRL = 10, C_WWD = 11, C_HLT = 12, C_ILL = 13;

  typedef struct packed {
    logic [3:0]  upc;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        wwd_en;
    logic        illegal;
    logic [1:0]  pc_src;
    logic [1:0]  wb_sel;
    logic [1:0]  reg_dst;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [15:0] num_inst;
    logic        halted;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n      [2];
  logic [15:0] instruction  [2];
  logic        mem_ready    [2];
  logic        branch_taken [2];

  logic [3:0]  upc_w  [2];
  logic        mr_w   [2];
  logic        mw_w   [2];
  logic        irw_w  [2];
  logic        pcw_w  [2];
  logic        rw_w   [2];
  logic        wwd_w  [2];
  logic        ill_w  [2];
  logic [1:0]  pcs_w  [2];
  logic [1:0]  wbs_w  [2];
  logic [1:0]  rd_w   [2];
  logic [3:0]  alu_w  [2];
  logic        alus_w [2];
  logic [15:0] num_w  [2];
  logic        hlt_w  [2];

  obs_t got       [2];
  obs_t exp_obs   [2];
  logic exp_valid [2];
  int   model_cnt [2];
  int   lat_of    [2] = '{0, 3};
  int   compared   = 0;
  int   mismatched = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_ctrl_fsm #(.WORD_SIZE(16), .CNT_WIDTH(16), .MEM_LATENCY(g * 3)) dut (
      .clk          (clk),
      .reset_n      (reset_n[g]),
      .instruction  (instruction[g]),
      .mem_ready    (mem_ready[g]),
      .branch_taken (branch_taken[g]),
      .micro_pc     (upc_w[g]),
      .mem_read     (mr_w[g]),
      .mem_write    (mw_w[g]),
      .ir_write     (irw_w[g]),
      .pc_write     (pcw_w[g]),
      .reg_write    (rw_w[g]),
      .wwd_en       (wwd_w[g]),
      .illegal      (ill_w[g]),
      .pc_src       (pcs_w[g]),
      .wb_sel       (wbs_w[g]),
      .reg_dst      (rd_w[g]),
      .alu_op       (alu_w[g]),
      .alu_src      (alus_w[g]),
      .num_inst     (num_w[g]),
      .is_halted    (hlt_w[g])
    );
    assign got[g] = {upc_w[g], mr_w[g], mw_w[g], irw_w[g], pcw_w[g], rw_w[g], wwd_w[g], ill_w[g],
                     pcs_w[g], wbs_w[g], rd_w[g], alu_w[g], alus_w[g], num_w[g], hlt_w[g]};
  end

  function automatic int classify(logic [15:0] ins);
    logic [3:0] op;
    logic [5:0] fn;
    op = ins[15:12];
    fn = ins[5:0];
    if (op <= 4'd3) return C_BR;
    case (op)
      4'd4:  return C_ADI;
      4'd5:  return C_ORI;
      4'd6:  return C_LHI;
      4'd7:  return C_LWD;
      4'd8:  return C_SWD;
      4'd9:  return C_JMP;
      4'd10: return C_JAL;
      4'd15: begin
        if (fn <= 6'd7) return C_RALU;
        if (fn == 6'd25) return C_JPR;
        if (fn == 6'd26) return C_JRL;
        if (fn == 6'd28) return C_WWD;
        if (fn == 6'd29) return C_HLT;
        return C_ILL;
      end
      default: return C_ILL;
    endcase
  endfunction

  // Expected outputs for one cycle of a given phase of an instruction
  function automatic obs_t model_out(int d, int phase, logic [15:0] ins, logic bt, logic done);
    obs_t o;
    int   c;
    o = '0;
    c = classify(ins);
    o.upc      = 4'(phase);
    o.num_inst = 16'(model_cnt[d]);
    o.halted   = (phase == P_HALT);
    case (phase)
      P_IF: begin
        o.mem_read = 1'b1;
        o.ir_write = done;
        o.pc_write = done;
      end
      P_EX: begin
        case (c)
          C_BR:                      begin o.alu_src = 1'b1; o.pc_write = bt; o.pc_src = 2'd1; end
          C_ADI, C_LWD, C_SWD:       o.alu_src = 1'b1;
          C_ORI:                     begin o.alu_op = 4'd3; o.alu_src = 1'b1; end
          C_LHI:                     begin o.alu_op = 4'd8; o.alu_src = 1'b1; end
          C_JMP, C_JAL:              begin o.pc_write = 1'b1; o.pc_src = 2'd2; end
          C_RALU, C_WWD:             o.alu_op = ins[3:0];
          C_JPR, C_JRL:              begin o.alu_op = ins[3:0]; o.pc_write = 1'b1; o.pc_src = 2'd3; end
          C_ILL:                     o.illegal = 1'b1;
          default: ;
        endcase
        o.wwd_en = (c == C_WWD);
      end
      P_MEM: begin
        o.mem_read  = (c == C_LWD);
        o.mem_write = (c == C_SWD);
      end
      P_WB: begin
        o.reg_write = 1'b1;
        case (c)
          C_RALU:       o.reg_dst = 2'd1;
          C_LWD:        o.wb_sel = 2'd1;
          C_JAL, C_JRL: begin o.wb_sel = 2'd2; o.reg_dst = 2'd2; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic pick_ready(int mode, int phase, int n);
    case (mode)
      1:       return 1'b1;
      2:       return (phase == P_IF) ? 1'b1 : (n > 2);
      3:       return 1'b0;
      default: return (n >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    int          k;
    r = 16'($urandom);
    k = $urandom_range(0, 15);
    r[15:12] = 4'(k);
    if (k == 15) begin
      case ($urandom_range(0, 5))
        0, 1:    r[5:0] = 6'($urandom_range(0, 7));
        2:       r[5:0] = 6'd25;
        3:       r[5:0] = 6'd26;
        4:       r[5:0] = 6'd28;
        default: if (r[5:0] == 6'd29) r[5:0] = 6'd30;
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(int d);
    compared++;
    if (got[d] !== exp_obs[d]) begin
      mismatched++;
      $display("[TB] FAIL cycle_outputs dut%0d t=%0t: got %h required %h", d, $time, got[d], exp_obs[d]);
    end
  endtask

  task automatic check_lit(string nm, int d, int act, int want);
    compared++;
    if (act != want) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d: got %0d required %0d", nm, d, act, want);
    end
  endtask

  task automatic applyStimulus(int d, int phase, logic [15:0] ins, logic rdy, logic bt, logic done,
                               logic rst_n);
    @(negedge clk);
    instruction[d]  = ins;
    mem_ready[d]    = rdy;
    branch_taken[d] = bt;
    reset_n[d]      = rst_n;
    exp_obs[d]      = model_out(d, phase, ins, bt, done);
    exp_valid[d]    = 1'b1;
    @(posedge clk);
  endtask

  // Walks one instruction along its route; optionally resets on the first MEM cycle
  task automatic run_instr(int d, logic [15:0] ins, int mode, logic bt, bit abort_mem, output int cycles);
    int   c;
    int   route[$];
    int   n;
    logic rdy;
    logic done;
    c      = classify(ins);
    cycles = 0;
    route  = '{P_IF, P_ID};
    if (c != C_HLT) begin
      route.push_back(P_EX);
      if (c == C_LWD) begin
        route.push_back(P_MEM);
        route.push_back(P_WB);
      end else if (c == C_SWD) begin
        route.push_back(P_MEM);
      end else if (c inside {C_RALU, C_ADI, C_ORI, C_LHI, C_JAL, C_JRL}) begin
        route.push_back(P_WB);
      end
    end
    foreach (route[i]) begin
      if (route[i] == P_IF || route[i] == P_MEM) begin
        n    = 0;
        done = 1'b0;
        while (!done) begin
          n++;
          if (abort_mem && route[i] == P_MEM) begin
            applyStimulus(d, P_MEM, ins, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            model_cnt[d] = 0;
            cycles++;
            return;
          end
          rdy  = pick_ready(mode, route[i], n);
          done = (lat_of[d] == 0) ? rdy : (n == lat_of[d]);
          if (n > 40) begin
            mismatched++;
            $display("[TB] FAIL mem_wait_bound dut%0d: got %0d cycles required <= 40", d, n);
            done = 1'b1;
          end
          applyStimulus(d, route[i], ins, rdy, 1'($urandom_range(0, 1)), done, 1'b1);
          cycles++;
        end
      end else begin
        applyStimulus(d, route[i], ins, 1'($urandom_range(0, 1)),
                      (route[i] == P_EX) ? bt : 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        cycles++;
      end
    end
    model_cnt[d]++;
  endtask

  task automatic run_program(int d);
    int cyc;
    run_instr(d, 16'hF6C0, 1, 1'b0, 1'b0, cyc);
    check_lit("add_cycles", d, cyc, (d == 0) ? 4 : 6);
    run_instr(d, 16'h7100, (d == 0) ? 2 : 3, 1'b0, 1'b0, cyc);
    check_lit("lwd_cycles", d, cyc, (d == 0) ? 7 : 9);
    run_instr(d, 16'h1000, 1, 1'b1, 1'b0, cyc);
    check_lit("beq_taken_cycles", d, cyc, (d == 0) ? 3 : 5);
    run_instr(d, 16'h1000, 1, 1'b0, 1'b0, cyc);
    check_lit("beq_not_taken_cycles", d, cyc, (d == 0) ? 3 : 5);
    run_instr(d, 16'h5000, 1, 1'b0, 1'b0, cyc);
    run_instr(d, 16'hF01D, 1, 1'b0, 1'b0, cyc);
    check_lit("hlt_cycles", d, cyc, (d == 0) ? 2 : 4);
    #1;
    check_lit("halt_micro_pc", d, int'(upc_w[d]), 15);
    check_lit("halt_num_inst", d, int'(num_w[d]), 6);
    check_lit("halt_flag", d, int'(hlt_w[d]), 1);
    repeat (20) applyStimulus(d, P_HALT, 16'($urandom), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'b0, 1'b1);
    applyStimulus(d, P_HALT, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    model_cnt[d] = 0;
    for (int i = 0; i < 60; i++) begin
      run_instr(d, rand_instr(), 0, 1'($urandom_range(0, 1)), 1'b0, cyc);
    end
    run_instr(d, 16'h8100, 1, 1'b0, 1'b1, cyc);
    #1;
    check_lit("reset_mid_mem_micro_pc", d, int'(upc_w[d]), 0);
    check_lit("reset_mid_mem_num_inst", d, int'(num_w[d]), 0);
    check_lit("reset_mid_mem_mem_read", d, int'(mr_w[d]), 1);
    check_lit("reset_mid_mem_mem_write", d, int'(mw_w[d]), 0);
    run_instr(d, 16'hB000, 1, 1'b0, 1'b0, cyc);
    check_lit("illegal_cycles", d, cyc, (d == 0) ? 3 : 5);
    #1;
    check_lit("illegal_num_inst", d, int'(num_w[d]), 1);
    exp_valid[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (exp_valid[d]) checkOutput(d);
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_n[d]      = 1'b0;
      instruction[d]  = 16'h0000;
      mem_ready[d]    = 1'b0;
      branch_taken[d] = 1'b0;
      exp_valid[d]    = 1'b0;
      model_cnt[d]    = 0;
    end
    repeat (2) @(posedge clk);
    fork
      run_program(0);
      run_program(1);
    join
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
